// File: rtl/mem_loader.sv
// Step-driven RAM loader: collects a hi and a lo byte from switches per word,
// writes the word at an incrementing address, and stops after LAST_ADDR.
module mem_loader #(
  parameter int unsigned            ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]      LAST_ADDR = ADDR_W'(8'hFF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              step,
  input  logic [7:0]        sw,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_din,
  output logic              load_active,
  output logic              done,
  output logic [2:0]        state_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_HI = 3'd1,
    GET_LO = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [7:0]        hi_byte, hi_nxt;
  logic [7:0]        lo_byte, lo_nxt;
  logic              step_q;
  logic              step_rise;

  assign step_rise = step & ~step_q;

  // Next-state; dropping load_en wins over everything, including a step edge
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    hi_nxt    = hi_byte;
    lo_nxt    = lo_byte;
    if (!load_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = GET_HI;
          addr_nxt  = '0;
        end
        GET_HI: begin
          if (step_rise) begin
            hi_nxt    = sw;
            state_nxt = GET_LO;
          end
        end
        GET_LO: begin
          if (step_rise) begin
            lo_nxt    = sw;
            state_nxt = WRITE;
          end
        end
        WRITE: begin
          if (addr == LAST_ADDR) begin
            state_nxt = DONE;
          end else begin
            addr_nxt  = addr + ADDR_W'(1);
            state_nxt = GET_HI;
          end
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and output registers; step_q resets high so a held step is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      hi_byte     <= '0;
      lo_byte     <= '0;
      step_q      <= 1'b1;
      ram_we      <= 1'b0;
      load_active <= 1'b0;
      done        <= 1'b0;
      state_out   <= 3'd0;
    end else begin
      state       <= state_nxt;
      addr        <= addr_nxt;
      hi_byte     <= hi_nxt;
      lo_byte     <= lo_nxt;
      step_q      <= step;
      ram_we      <= (state_nxt == WRITE);
      load_active <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
      state_out   <= 3'(state_nxt);
    end
  end

  assign ram_addr = addr;
  assign ram_din  = {hi_byte, lo_byte};

endmodule
